dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//   Data-memory responder for the core's DM port: receives addr/cs/rw/data, answers reads one
//   cycle later. Memory is a doubleword array behind an init sequencer that zeroes it after
//   reset. Sits beside the core in the top level, wired to o_dm_*/i_dm_data.
// PARAMETERS
//   ADDR_W   10   byte-address bits used; depth = 2**(ADDR_W-3) doublewords (default 128)
//   DATA_W   64   bus width; fixed at 64, other values unsupported
// PORTS
//   i_clk         in   1       clock; all state updates on rising edge
//   i_rst         in   1       reset, synchronous, active-high
//   i_dm_addr     in   64      byte address; only [ADDR_W-1:0] decoded, upper bits ignored
//   i_dm_cs       in   1       chip select; access valid only when high
//   i_dm_rw       in   1       1 = write, 0 = read
//   i_dm_data     in   64      write data, bus byte order (addr+0 in [63:56] ... addr+7 in [7:0])
//   o_dm_data     out  64      read data, same bus byte order, registered
//   o_init_done   out  1       high once post-reset zeroing has completed
//   o_err         out  1       one-cycle pulse: misaligned access (addr[2:0] != 0) accepted
// BEHAVIOUR
//   Reset: o_dm_data=0, o_init_done=0, o_err=0, FSM->INIT, clear index=0. Array contents
//     are not reset directly; the INIT state clears them.
//   FSM: INIT -> RUN. INIT writes 0 to word[idx] each cycle, idx++; after writing the last
//     index (depth-1) -> RUN, o_init_done=1 from the next cycle. RUN is terminal until i_rst.
//   INIT takes exactly depth cycles (128 by default). Accesses during INIT are ignored:
//     no write, o_dm_data holds 0, o_err stays 0.
//   Word index = addr[ADDR_W-1:3]. Bus data is stored verbatim; no byte swap in this block.
//   Write (RUN, cs=1, rw=1, aligned): word[idx] <= i_dm_data at the edge. o_dm_data unchanged.
//   Read (RUN, cs=1, rw=0, aligned): o_dm_data <= word[idx] at the edge. Latency is 1 cycle:
//     data is valid in the cycle after the address is presented.
//   Read in the cycle right after a write to the same word returns the new data.
//   The port is single-access: write and read never occur in the same cycle.
//   cs=0: no array access, o_dm_data holds its last value.
//   Misaligned access (cs=1, addr[2:0]!=0): write suppressed / read leaves o_dm_data held;
//     o_err=1 for exactly the following cycle.
//   Address wrap: bits above ADDR_W-1 are ignored, so addr 0x400 aliases addr 0x000.
//   i_rst mid-operation, in any state, restarts INIT from idx 0. Writes issued earlier are lost.
// CONFIGURATION
//   `DM_STATS_EN defined: adds outputs o_rd_cnt[31:0] and o_wr_cnt[31:0].
//     - Each counts accepted aligned RUN-state reads / writes.
//     - Both are 0 at reset and saturate at 32'hFFFF_FFFF.
//     - Misaligned and INIT-state accesses are not counted.
//   Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//   Package dm_pkg:
//     - localparams DM_ADDR_W=10, DM_DATA_W=64, DM_DEPTH=2**(DM_ADDR_W-3)
//     - typedef enum logic [0:0] {DM_INIT, DM_RUN} dm_state_t
//     - function dm_aligned(addr)
//   Sub-module dm_array: single-port synchronous RAM, DM_DEPTH x 64.
//     - Ports: clk, we, addr, wdata, re, rdata; registered rdata.
//     - The top level muxes INIT-clear vs. bus access onto it.
// TESTING
//   1 Reset, idle -> o_init_done rises exactly 129 cycles after i_rst falls; read of addr 0x3F8
//     then returns 64'h0.
//   2 After init, write 0x10 data 64'h0123_4567_89AB_CDEF; next cycle read 0x10
//     -> o_dm_data = 64'h0123_4567_89AB_CDEF one cycle later.
//   3 Write 0x08 = 64'hAA..AA; read 0x408 -> 64'hAA..AA (alias); read 0x00 -> 64'h0.
//   4 Write 0x0C (misaligned) -> o_err pulses 1 cycle, read 0x08 still returns prior value,
//     o_dm_data held during the errored cycle.
//   5 During INIT (cycle 10) write 0x20 = 64'hFF..FF -> after init, read 0x20 returns 64'h0.
//     Assert i_rst mid-RUN -> o_init_done=0 next cycle, all words read 0 after re-init.
//   6 With DM_STATS_EN: 3 reads, 2 writes, 1 misaligned -> o_rd_cnt=3, o_wr_cnt=2.
//     Preload o_wr_cnt=32'hFFFF_FFFF via force, then write -> stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants, FSM state type and address helper for the data-memory responder.
// Optional statistics counters are enabled with `DM_STATS_EN.
package dm_pkg;
    localparam int DM_ADDR_W = 10;
    localparam int DM_DATA_W = 64;
    localparam int DM_DEPTH  = 2**(DM_ADDR_W-3);

    typedef enum logic [0:0] {DM_INIT, DM_RUN} dm_state_t;

    function automatic logic dm_aligned(input logic [63:0] addr);
        return addr[2:0] == 3'b000;
    endfunction
endpackage

// File: rtl/dm_responder_if.sv
// DM bus between the core and dm_responder; o_rd_cnt/o_wr_cnt exist only with `DM_STATS_EN.
interface dm_responder_if;
    import dm_pkg::*;

    logic [DM_DATA_W-1:0] i_dm_addr;
    logic                 i_dm_cs;
    logic                 i_dm_rw;
    logic [DM_DATA_W-1:0] i_dm_data;
    logic [DM_DATA_W-1:0] o_dm_data;
    logic                 o_init_done;
    logic                 o_err;
`ifdef DM_STATS_EN
    logic [31:0]          o_rd_cnt;
    logic [31:0]          o_wr_cnt;
`endif

    modport master (
        output i_dm_addr, i_dm_cs, i_dm_rw, i_dm_data,
        input  o_dm_data, o_init_done, o_err
`ifdef DM_STATS_EN
        , input o_rd_cnt, o_wr_cnt
`endif
    );

    modport slave (
        input  i_dm_addr, i_dm_cs, i_dm_rw, i_dm_data,
        output o_dm_data, o_init_done, o_err
`ifdef DM_STATS_EN
        , output o_rd_cnt, o_wr_cnt
`endif
    );
endinterface

// File: rtl/dm_array.sv
// Single-port synchronous doubleword RAM with registered read data.
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [DM_DATA_W-1:0] wdata,
    input  logic                 re,
    output logic [DM_DATA_W-1:0] rdata
);
    logic [DM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: zeroes the array after reset, then serves 1-cycle-latency reads/writes.
// Defining `DM_STATS_EN adds saturating accepted-read/write counters on the interface.
module dm_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dm_responder_if.slave  dm
);
    localparam int IDX_W = ADDR_W - 3;
    localparam int DEPTH = 2**IDX_W;

    dm_state_t         state;
    logic [IDX_W-1:0]  clr_idx;
    logic              run;
    logic              aligned;
    logic              acc;
    logic              bus_we;
    logic              bus_re;
    logic              data_vld;
    logic              init_done;
    logic              err;
    logic [IDX_W-1:0]  bus_idx;
    logic [IDX_W-1:0]  arr_addr;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              unused_addr;

    assign run     = (state == DM_RUN);
    assign aligned = dm_aligned(dm.i_dm_addr);
    assign acc     = run & ~i_rst & dm.i_dm_cs & aligned;
    assign bus_we  = acc & dm.i_dm_rw;
    assign bus_re  = acc & ~dm.i_dm_rw;
    assign bus_idx = dm.i_dm_addr[ADDR_W-1:3];
    assign unused_addr = &{1'b0, dm.i_dm_addr[63:ADDR_W]};

    // The clear sequencer owns the RAM port until the last word is zeroed.
    always_comb begin
        arr_addr  = clr_idx;
        arr_we    = 1'b1;
        arr_wdata = '0;
        if (run) begin
            arr_addr  = bus_idx;
            arr_we    = bus_we;
            arr_wdata = dm.i_dm_data;
        end
    end

    dm_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (i_clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .re    (bus_re),
        .rdata (arr_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= DM_INIT;
            clr_idx   <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
            data_vld  <= 1'b0;
        end else begin
            if (!run) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == IDX_W'(DEPTH - 1))
                    state <= DM_RUN;
            end
            init_done <= run;
            err       <= run & dm.i_dm_cs & ~aligned;
            if (bus_re)
                data_vld <= 1'b1;
        end
    end

    // RAM output register has no reset; present zero until the first accepted read.
    assign dm.o_dm_data   = data_vld ? arr_rdata : '0;
    assign dm.o_init_done = init_done;
    assign dm.o_err       = err;

`ifdef DM_STATS_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (bus_re && rd_cnt != '1)
                rd_cnt <= rd_cnt + 1'b1;
            if (bus_we && wr_cnt != '1)
                wr_cnt <= wr_cnt + 1'b1;
        end
    end

    assign dm.o_rd_cnt = rd_cnt;
    assign dm.o_wr_cnt = wr_cnt;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: cycle model plus directed literal checks.
// Counter checks are compiled in when `DM_STATS_EN is defined.
module tb_dm_responder;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_responder_if dmif();

    dm_responder #(
        .ADDR_W (DM_ADDR_W),
        .DATA_W (DM_DATA_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .dm    (dmif)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: memory is all-zero after reset; RUN begins once DEPTH non-reset edges have passed.
    logic [63:0] mdl_mem [DM_DEPTH];
    logic [63:0] exp_data;
    logic        exp_err;
    logic        exp_done;
    int          edges;
`ifdef DM_STATS_EN
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
`endif

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  w;
        bit  in_run;
        if (rst) begin
            edges    = 0;
            exp_data = '0;
            exp_err  = 1'b0;
            exp_done = 1'b0;
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
`ifdef DM_STATS_EN
            exp_rd = '0;
            exp_wr = '0;
`endif
        end else begin
            in_run  = (edges >= DM_DEPTH);
            exp_err = 1'b0;
            w = int'(dmif.i_dm_addr[DM_ADDR_W-1:3]);
            if (in_run && dmif.i_dm_cs) begin
                if (dmif.i_dm_addr[2:0] != 3'b000) begin
                    exp_err = 1'b1;
                end else if (dmif.i_dm_rw) begin
                    mdl_mem[w] = dmif.i_dm_data;
`ifdef DM_STATS_EN
                    if (exp_wr != 32'hFFFF_FFFF) exp_wr = exp_wr + 1;
`endif
                end else begin
                    exp_data = mdl_mem[w];
`ifdef DM_STATS_EN
                    if (exp_rd != 32'hFFFF_FFFF) exp_rd = exp_rd + 1;
`endif
                end
            end
            edges++;
            exp_done = (edges >= DM_DEPTH + 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check64("o_dm_data", dmif.o_dm_data, exp_data);
            check64("o_err", {63'b0, dmif.o_err}, {63'b0, exp_err});
            check64("o_init_done", {63'b0, dmif.o_init_done}, {63'b0, exp_done});
`ifdef DM_STATS_EN
            check64("o_rd_cnt", {32'b0, dmif.o_rd_cnt}, {32'b0, exp_rd});
            check64("o_wr_cnt", {32'b0, dmif.o_wr_cnt}, {32'b0, exp_wr});
`endif
        end
    end

    task automatic drive(input logic cs, input logic rw, input logic [63:0] a, input logic [63:0] d);
        dmif.i_dm_cs   = cs;
        dmif.i_dm_rw   = rw;
        dmif.i_dm_addr = a;
        dmif.i_dm_data = d;
    endtask

    task automatic access(input logic rw, input logic [63:0] a, input logic [63:0] d);
        drive(1'b1, rw, a, d);
        @(negedge clk);
        drive(1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic read_chk(input string name, input logic [63:0] a, input logic [63:0] exp);
        access(1'b0, a, 64'h0);
        check64(name, dmif.o_dm_data, exp);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (dmif.o_init_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check64("init_done_reached", {63'b0, dmif.o_init_done}, 64'h1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check64("reset_dm_data", dmif.o_dm_data, 64'h0);
        check64("reset_init_done", {63'b0, dmif.o_init_done}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        wait_init(n);
        check64("init_latency", 64'(n), 64'd129);
        read_chk("rd_last_word", 64'h3F8, 64'h0);

        access(1'b1, 64'h10, 64'h0123_4567_89AB_CDEF);
        read_chk("rd_after_wr", 64'h10, 64'h0123_4567_89AB_CDEF);

        access(1'b1, 64'h08, 64'hAAAA_AAAA_AAAA_AAAA);
        read_chk("rd_alias_408", 64'h408, 64'hAAAA_AAAA_AAAA_AAAA);
        read_chk("rd_zero_word", 64'h00, 64'h0);

        access(1'b1, 64'h0C, 64'h5555_5555_5555_5555);
        check64("misalign_err", {63'b0, dmif.o_err}, 64'h1);
        check64("misalign_hold", dmif.o_dm_data, 64'h0);
        @(negedge clk);
        check64("err_one_cycle", {63'b0, dmif.o_err}, 64'h0);
        read_chk("rd_after_misalign", 64'h08, 64'hAAAA_AAAA_AAAA_AAAA);
        access(1'b0, 64'h11, 64'h0);
        check64("misalign_rd_err", {63'b0, dmif.o_err}, 64'h1);
        check64("misalign_rd_hold", dmif.o_dm_data, 64'hAAAA_AAAA_AAAA_AAAA);

        access(1'b1, 64'h3F8, 64'hDEAD_BEEF_0BAD_F00D);
        read_chk("rd_alias_7f8", 64'h7F8, 64'hDEAD_BEEF_0BAD_F00D);
        drive(1'b0, 1'b0, 64'h10, 64'h0);
        repeat (3) @(negedge clk);
        check64("cs_low_hold", dmif.o_dm_data, 64'hDEAD_BEEF_0BAD_F00D);

        do_reset();
        repeat (9) @(negedge clk);
        access(1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_init(n);
        read_chk("init_write_ignored", 64'h20, 64'h0);

        access(1'b1, 64'h18, 64'h1234_5678_9ABC_DEF0);
        read_chk("rd_before_rerst", 64'h18, 64'h1234_5678_9ABC_DEF0);
        rst = 1'b1;
        @(negedge clk);
        check64("rerst_init_done", {63'b0, dmif.o_init_done}, 64'h0);
        rst = 1'b0;
        wait_init(n);
        check64("reinit_latency", 64'(n), 64'd129);
        read_chk("rerst_cleared_18", 64'h18, 64'h0);
        read_chk("rerst_cleared_3f8", 64'h3F8, 64'h0);

`ifdef DM_STATS_EN
        do_reset();
        wait_init(n);
        access(1'b0, 64'h00, 64'h0);
        access(1'b1, 64'h08, 64'h1);
        access(1'b0, 64'h08, 64'h0);
        access(1'b1, 64'h0C, 64'h2);
        access(1'b1, 64'h10, 64'h3);
        access(1'b0, 64'h10, 64'h0);
        check64("stats_rd", {32'b0, dmif.o_rd_cnt}, 64'd3);
        check64("stats_wr", {32'b0, dmif.o_wr_cnt}, 64'd2);
        force dut.wr_cnt = 32'hFFFF_FFFF;
        exp_wr = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wr_cnt;
        access(1'b1, 64'h18, 64'h4);
        check64("stats_wr_sat", {32'b0, dmif.o_wr_cnt}, 64'h0000_0000_FFFF_FFFF);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
